// File: rtl/adder_seq_ctrl_if.sv
// rtl/adder_seq_ctrl_if.sv - operand, slice and result bus for adder_seq_ctrl
// The sub port exists only when ADDER_SEQ_SUB_EN is defined.
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADDER_SEQ_SUB_EN
  logic             sub;
`endif
  logic [3:0]       slice_r1;
  logic [3:0]       slice_r2;
  logic             slice_ci;
  logic [3:0]       slice_result;
  logic             slice_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // master: CPU execute stage plus the shared 4-bit adder
  modport master (
    output in_valid, a, b, cin,
`ifdef ADDER_SEQ_SUB_EN
    output sub,
`endif
    input  in_ready,
    input  slice_r1, slice_r2, slice_ci,
    output slice_result, slice_carry,
    input  out_valid, sum, cout, ovf,
    output out_ready
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADDER_SEQ_SUB_EN
    input  sub,
`endif
    output in_ready,
    output slice_r1, slice_r2, slice_ci,
    input  slice_result, slice_carry,
    output out_valid, sum, cout, ovf,
    input  out_ready
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - WIDTH-bit add sequenced through one external 4-bit adder slice
// Optional subtract mode enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  adder_seq_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic [WIDTH-5:0] sum_sh;
  logic             carry, sa, sb, cout_r, ovf_r;
  logic             accept, last_step, sub_sel;
  logic [WIDTH-1:0] b_eff;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign b_eff     = sub_sel ? ~bus.b : bus.b;
  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == RUN) && (idx == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last_step)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= b_eff;
      carry <= sub_sel ? 1'b1 : bus.cin;
      idx   <= '0;
      sa    <= bus.a[WIDTH-1];
      sb    <= b_eff[WIDTH-1];
    end else if (state == RUN) begin
      // Completed nibbles enter from the top; after NSLICE-1 steps nibble 0 sits at bit 0.
      sum_sh <= (WIDTH-4)'({bus.slice_result, sum_sh} >> 4);
      a_sh   <= a_sh >> 4;
      b_sh   <= b_sh >> 4;
      carry  <= bus.slice_carry;
      idx    <= idx + 1'b1;
      if (last_step) begin
        sum_r  <= {bus.slice_result, sum_sh};
        cout_r <= bus.slice_carry;
        ovf_r  <= (sa == sb) && (bus.slice_result[3] != sa);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.slice_r1  = (state == RUN) ? a_sh[3:0] : 4'h0;
  assign bus.slice_r2  = (state == RUN) ? b_sh[3:0] : 4'h0;
  assign bus.slice_ci  = (state == RUN) ? carry : 1'b0;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - directed self-checking bench for adder_seq_ctrl (WIDTH=32)
// Define ADDER_SEQ_SUB_EN to also exercise subtract mode.
module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl_if #(.WIDTH(32)) bus();

  adder_seq_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // behavioural model of the shared 4-bit ripple adder
  assign {bus.slice_carry, bus.slice_result} =
      {1'b0, bus.slice_r1} + {1'b0, bus.slice_r2} + {4'b0, bus.slice_ci};

  // Presents one operand set, waits for completion; leaves the result pending in DONE.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, output logic [3:0] r1_0, output logic [3:0] r2_0,
                          output logic ci_0, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub requested without ADDER_SEQ_SUB_EN");
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    r1_0 = bus.slice_r1; r2_0 = bus.slice_r2; ci_0 = bus.slice_ci;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 32'h0 ||
        bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    checks++;
    if (bus.slice_r1 !== 4'h0 || bus.slice_r2 !== 4'h0 || bus.slice_ci !== 1'b0) begin
      failures++;
      $display("FAIL reset_slice: r1=%h r2=%h ci=%b, required 0 0 0",
               bus.slice_r1, bus.slice_r2, bus.slice_ci);
    end
  endtask

  task automatic test_add_vectors();
    logic [31:0] va [3] = '{32'h0000000A, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] vb [3] = '{32'h00000002, 32'h00000001, 32'h00000000};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] es [3] = '{32'h0000000C, 32'h00000000, 32'h80000000};
    logic        eco[3] = '{1'b0, 1'b1, 1'b0};
    logic        eov[3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0]  r1, r2;
    logic        ci;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], vc[i], 1'b0, r1, r2, ci, lat);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL add%0d_latency: got %0d edges, required 8", i, lat);
      end
      checks++;
      if (r1 !== va[i][3:0] || r2 !== vb[i][3:0] || ci !== vc[i]) begin
        failures++;
        $display("FAIL add%0d_first_slice: r1=%h r2=%h ci=%b, required %h %h %b",
                 i, r1, r2, ci, va[i][3:0], vb[i][3:0], vc[i]);
      end
      checks++;
      if (bus.sum !== es[i] || bus.cout !== eco[i] || bus.ovf !== eov[i]) begin
        failures++;
        $display("FAIL add%0d_result: sum=%h cout=%b ovf=%b, required %h %b %b",
                 i, bus.sum, bus.cout, bus.ovf, es[i], eco[i], eov[i]);
      end
      finish_op();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== es[i]) begin
        failures++;
        $display("FAIL add%0d_release: out_valid=%b in_ready=%b sum=%h, required 0 1 %h",
                 i, bus.out_valid, bus.in_ready, bus.sum, es[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] r1, r2;
    logic       ci;
    int         lat;
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, r1, r2, ci, lat);
    for (int k = 0; k < 5; k++) begin
      bus.a = 32'hDEAD0000 + k; bus.b = 32'h1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.sum !== 32'h23456789 || bus.cout !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b sum=%h cout=%b, required 1 0 23456789 0",
                 k, bus.out_valid, bus.in_ready, bus.sum, bus.cout);
      end
    end
    finish_op();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.slice_r1 !== 4'h0) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b r1=%h, required 1 for in_ready, 0 otherwise",
               bus.out_valid, bus.in_ready, bus.slice_r1);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] r1, r2;
    logic       ci;
    int         lat;
    bus.a = 32'hFFFFFFFF; bus.b = 32'h1; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 32'h0 ||
        bus.cout !== 1'b0 || bus.ovf !== 1'b0 || bus.slice_r1 !== 4'h0 || bus.slice_ci !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b r1=%h ci=%b, required 0 1 0 0 0 0 0",
               bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf, bus.slice_r1, bus.slice_ci);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    start_op(32'h1, 32'h1, 1'b0, 1'b0, r1, r2, ci, lat);
    checks++;
    if (lat !== 8 || bus.sum !== 32'h2 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_op: lat=%0d sum=%h cout=%b ovf=%b, required 8 00000002 0 0",
               lat, bus.sum, bus.cout, bus.ovf);
    end
    finish_op();
  endtask

`ifdef ADDER_SEQ_SUB_EN
  task automatic test_sub();
    logic [3:0] r1, r2;
    logic       ci;
    int         lat;
    start_op(32'h5, 32'h7, 1'b0, 1'b1, r1, r2, ci, lat);
    checks++;
    if (lat !== 8 || bus.sum !== 32'hFFFFFFFE || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL sub_5_7: lat=%0d sum=%h cout=%b ovf=%b, required 8 fffffffe 0 0",
               lat, bus.sum, bus.cout, bus.ovf);
    end
    finish_op();
    start_op(32'h7, 32'h5, 1'b0, 1'b1, r1, r2, ci, lat);
    checks++;
    if (bus.sum !== 32'h2 || bus.cout !== 1'b1 || bus.ovf !== 1'b0 || ci !== 1'b1) begin
      failures++;
      $display("FAIL sub_7_5: sum=%h cout=%b ovf=%b ci0=%b, required 00000002 1 0 1",
               bus.sum, bus.cout, bus.ovf, ci);
    end
    finish_op();
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_add_vectors();
    test_backpressure();
    test_reset_mid_run();
`ifdef ADDER_SEQ_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
